// File: rtl/adc_avg_pkg.sv
// Shared sequencer CSR encodings and sequencer state type for the ADC
// channel averager.
package adc_avg_pkg;

    localparam logic             SEQ_CMD_ADDR  = 1'b0;
    localparam int unsigned      SEQ_RUN_BIT   = 0;
    localparam logic [2:0]       SEQ_MODE_CONT = 3'b000;
    localparam logic [31:0]      SEQ_CMD_RUN   = 32'h0000_0001;
    localparam logic [31:0]      SEQ_CMD_STOP  = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_START = 2'd1,
        SEQ_RUN   = 2'd2,
        SEQ_STOP  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/adc_channel_averager_if.sv
// Sequencer CSR port and single-sample response stream of the modular ADC IP.
interface adc_seq_csr_if;
    logic        seq_csr_address;
    logic        seq_csr_read;
    logic        seq_csr_write;
    logic [31:0] seq_csr_writedata;

    modport master (output seq_csr_address, seq_csr_read, seq_csr_write, seq_csr_writedata);
    modport slave  (input  seq_csr_address, seq_csr_read, seq_csr_write, seq_csr_writedata);
endinterface

interface adc_rsp_if #(
    parameter int unsigned DATA_W = 12
);
    logic              rsp_valid;
    logic [4:0]        rsp_channel;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_sop;
    logic              rsp_eop;

    modport master (output rsp_valid, rsp_channel, rsp_data, rsp_sop, rsp_eop);
    modport slave  (input  rsp_valid, rsp_channel, rsp_data, rsp_sop, rsp_eop);
endinterface

// File: rtl/adc_avg_seq_ctrl.sv
// Four-state sequencer controller: issues the run/stop CSR writes and tells
// the datapath when averaging is active, when to flush and when it is idle.
module adc_avg_seq_ctrl
    import adc_avg_pkg::*;
(
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    input  logic          enable,
    adc_seq_csr_if.master seq_csr,
    output logic          idle_o,
    output logic          run_o,
    output logic          stop_o
);

    seq_state_e  state_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic        idle_q;
    logic        run_q;
    logic        stop_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= SEQ_IDLE;
            write_q <= 1'b0;
            wdata_q <= SEQ_CMD_STOP;
            idle_q  <= 1'b1;
            run_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            write_q <= 1'b0;
            stop_q  <= 1'b0;
            unique case (state_q)
                SEQ_IDLE: if (enable) begin
                    state_q <= SEQ_START;
                    write_q <= 1'b1;
                    wdata_q <= SEQ_CMD_RUN;
                    idle_q  <= 1'b0;
                end
                SEQ_START: begin
                    state_q <= SEQ_RUN;
                    run_q   <= 1'b1;
                end
                SEQ_RUN: if (!enable) begin
                    state_q <= SEQ_STOP;
                    write_q <= 1'b1;
                    wdata_q <= SEQ_CMD_STOP;
                    run_q   <= 1'b0;
                    stop_q  <= 1'b1;
                end
                SEQ_STOP: begin
                    state_q <= SEQ_IDLE;
                    idle_q  <= 1'b1;
                end
                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

    assign seq_csr.seq_csr_address   = SEQ_CMD_ADDR;
    assign seq_csr.seq_csr_read      = 1'b0;
    assign seq_csr.seq_csr_write     = write_q;
    assign seq_csr.seq_csr_writedata = wdata_q;
    assign idle_o = idle_q;
    assign run_o  = run_q;
    assign stop_o = stop_q;

endmodule

// File: rtl/adc_channel_averager.sv
// Per-channel 2^LOG2_AVG sample averager behind the ADC sequencer, with a
// readable result store, new-data flags and sticky overrun.
module adc_channel_averager
    import adc_avg_pkg::*;
#(
    parameter int unsigned  NUM_CH   = 8,
    parameter int unsigned  CH_BASE  = 1,
    parameter int unsigned  DATA_W   = 12,
    parameter int unsigned  LOG2_AVG = 4,
    localparam int unsigned SLOT_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              enable,
    adc_seq_csr_if.master     seq_csr,
    adc_rsp_if.slave          rsp,
    input  logic [SLOT_W-1:0] rd_addr,
    input  logic              rd_strobe,
    output logic [DATA_W-1:0] rd_data,
    output logic [NUM_CH-1:0] new_data,
    output logic              avg_valid,
    output logic [SLOT_W-1:0] avg_slot,
    output logic [DATA_W-1:0] avg_data,
    output logic              overrun
);

    localparam int unsigned AW = DATA_W + LOG2_AVG;
    localparam int unsigned CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_AVG) - 1);

    logic idle, run, stop;

    adc_avg_seq_ctrl u_seq_ctrl (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .enable        (enable),
        .seq_csr       (seq_csr),
        .idle_o        (idle),
        .run_o         (run),
        .stop_o        (stop)
    );

    logic [AW-1:0]     acc_q [NUM_CH];
    logic [AW-1:0]     acc_d [NUM_CH];
    logic [CW-1:0]     cnt_q [NUM_CH];
    logic [CW-1:0]     cnt_d [NUM_CH];
    logic [DATA_W-1:0] res_q [NUM_CH];
    logic [DATA_W-1:0] res_d [NUM_CH];
    logic [NUM_CH-1:0] new_q, new_d;
    logic              ovr_q, ovr_d;
    logic              av_q, av_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [DATA_W-1:0] adata_q, adata_d;
    logic [DATA_W-1:0] rd_q;

    logic [6:0]        rel;
    logic              hit;
    logic [SLOT_W-1:0] slot;
    logic [AW-1:0]     sum;
    logic              unused_framing;

    // sop/eop carry no information for single-sample packets
    assign unused_framing = rsp.rsp_sop ^ rsp.rsp_eop;

    assign rel  = {2'b00, rsp.rsp_channel} - 7'(CH_BASE);
    assign hit  = run && rsp.rsp_valid && ({2'b00, rsp.rsp_channel} >= 7'(CH_BASE))
                  && (rel < 7'(NUM_CH));
    assign slot = rel[SLOT_W-1:0];
    assign sum  = acc_q[slot] + AW'(rsp.rsp_data);

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            acc_d[i] = stop ? '0 : acc_q[i];
            cnt_d[i] = stop ? '0 : cnt_q[i];
            res_d[i] = res_q[i];
        end
        new_d   = new_q;
        ovr_d   = ovr_q;
        av_d    = 1'b0;
        slot_d  = slot_q;
        adata_d = adata_q;

        if (rd_strobe) new_d[rd_addr] = 1'b0;
        if (idle && enable) ovr_d = 1'b0;

        // a completion is applied after the strobe clear so the set wins
        if (hit) begin
            if (cnt_q[slot] == CNT_LAST) begin
                res_d[slot]  = sum[AW-1:LOG2_AVG];
                adata_d      = sum[AW-1:LOG2_AVG];
                slot_d       = slot;
                av_d         = 1'b1;
                acc_d[slot]  = '0;
                cnt_d[slot]  = '0;
                new_d[slot]  = 1'b1;
                if (new_q[slot]) ovr_d = 1'b1;
            end else begin
                acc_d[slot] = sum;
                cnt_d[slot] = cnt_q[slot] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
                res_q[i] <= '0;
            end
            new_q   <= '0;
            ovr_q   <= 1'b0;
            av_q    <= 1'b0;
            slot_q  <= '0;
            adata_q <= '0;
            rd_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
                cnt_q[i] <= cnt_d[i];
                res_q[i] <= res_d[i];
            end
            new_q   <= new_d;
            ovr_q   <= ovr_d;
            av_q    <= av_d;
            slot_q  <= slot_d;
            adata_q <= adata_d;
            rd_q    <= res_q[rd_addr];
        end
    end

    assign rd_data   = rd_q;
    assign new_data  = new_q;
    assign avg_valid = av_q;
    assign avg_slot  = slot_q;
    assign avg_data  = adata_q;
    assign overrun   = ovr_q;

endmodule

// File: doc/adc_channel_averager.md
# adc_channel_averager

Downstream consumer of the modular ADC IP. Starts and stops the ADC sequencer through its CSR port, accepts the single-sample response stream, and averages 2^LOG2_AVG samples per channel. It holds one averaged 12-bit result per channel for the control logic to read, together with per-channel new-data flags, an event pulse per result, and sticky overrun detection.

## Interface
Parameters:
- NUM_CH, 8: number of averaged channels (slots 0..NUM_CH-1).
- CH_BASE, 1: ADC channel number mapped to slot 0.
- DATA_W, 12: ADC sample width.
- LOG2_AVG, 4: samples per average = 2^LOG2_AVG (legal 0..8).

Ports:
- clk_clk  in  1  system clock; same clock as the ADC IP clk_clk.
- reset_reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = run sequencer and average, 0 = stop.
- seq_csr_address  out  1  sequencer CSR address.
- seq_csr_read  out  1  never asserted; tied 0.
- seq_csr_write  out  1  one-cycle write strobe.
- seq_csr_writedata  out  32  sequencer command word.
- rsp_valid  in  1  ADC response valid.
- rsp_channel  in  5  ADC response channel.
- rsp_data  in  DATA_W  ADC response sample.
- rsp_sop, rsp_eop  in  1  ignored (single-sample packets).
- rd_addr  in  clog2(NUM_CH)  result slot select.
- rd_strobe  in  1  consume: clears new_data[rd_addr].
- rd_data  out  DATA_W  registered result of slot rd_addr.
- new_data  out  NUM_CH  per-slot unread-result flags.
- avg_valid  out  1  one-cycle pulse per completed average.
- avg_slot  out  clog2(NUM_CH)  slot of the completed average.
- avg_data  out  DATA_W  completed average.
- overrun  out  1  sticky; an unread result was overwritten.

## Operation
- Sequencer FSM states are IDLE, START, RUN and STOP.
  - IDLE: when enable=1, go to START.
  - START: for one cycle, drive seq_csr_write=1, address 0, writedata 0x0000_0001 (run bit set, mode 000 = continuous). Then go to RUN.
  - RUN: averaging is active. When enable=0, go to STOP.
  - STOP: for one cycle, write 0x0000_0000 to address 0. Clear all accumulators and counters. Then go to IDLE.
- Averaging is active only in RUN. In any other state, rsp_valid is ignored.
- A response is accepted when rsp_valid=1 and CH_BASE <= rsp_channel < CH_BASE+NUM_CH. Out-of-range channels are ignored silently.
- Each slot has a DATA_W+LOG2_AVG-bit accumulator and a LOG2_AVG-bit counter.
- On an accepted sample with counter < 2^LOG2_AVG-1: add the sample to the accumulator and increment the counter.
- On an accepted sample with counter = 2^LOG2_AVG-1:
  - result = (acc + sample) >> LOG2_AVG, truncating, no rounding.
  - Write result to the slot's result register and to avg_data; pulse avg_valid.
  - Clear the accumulator and counter to 0.
  - Set new_data[slot]. If new_data[slot] was already 1, set overrun.
- LOG2_AVG=0 gives pass-through: every sample completes a result.
- A set of new_data and a rd_strobe clear on the same slot in the same cycle: the set wins.
- overrun is cleared only by reset or by the IDLE->START transition.
- Result registers and new_data survive STOP. Partial averages do not.
- When enable drops mid-average, the partial sum is discarded.
- Reset values: every output 0, FSM in IDLE, all accumulators, counters, results and flags 0.

## Timing
- A sample accepted in cycle t produces avg_valid, avg_slot, avg_data, the result-register update and the new_data set at the clock edge ending cycle t. They are visible in t+1.
- rd_data is registered: rd_addr in cycle t gives rd_data in t+1. A result completing in t for slot rd_addr appears on rd_data in t+2.
- A rd_strobe in cycle t clears new_data visibly in t+1.
- The START write occurs in the cycle after enable is first sampled high. The STOP write occurs in the cycle after enable is first sampled low in RUN.
- enable toggling during START or STOP is evaluated only after that state completes.
- Back-to-back rsp_valid every cycle must be sustained with no stall; the block has no backpressure.

## Structure
- Package adc_avg_pkg holds:
  - SEQ_CMD_ADDR = 1'b0
  - SEQ_RUN_BIT = 0
  - SEQ_MODE_CONT = 3'b000
  - SEQ_CMD_RUN = 32'h1
  - SEQ_CMD_STOP = 32'h0
  - the sequencer state enum
- Sub-module adc_avg_seq_ctrl contains the four-state CSR FSM and outputs a run level. The datapath, accumulators and result store stay in the top module.

## Test plan
- Reset release, enable=1: exactly one write of 0x1 to address 0 two cycles later. Then enable=0: one write of 0x0, and the FSM returns to IDLE.
- LOG2_AVG=4, channel 1, sixteen samples of 0x800 then sixteen of 0xFFF: avg_valid pulses twice, slot 0, values 0x800 then 0xFFF, and no overflow.
- Channels 1 and 2 interleaved every cycle, samples 0..15 on ch1 and 0x100 on ch2: results are 0x007 for slot 0 and 0x100 for slot 1. Channel 0 and channel 9 traffic causes no change.
- Two completed averages on slot 3 with no rd_strobe: overrun=1. rd_strobe on slot 3 in the same cycle as a third completion: new_data[3] stays 1.
- Eight samples to slot 0, enable=0, re-enable, then sixteen samples of 0x010: result is 0x010, proving the partial sum was discarded. Earlier results are still readable after STOP.
- Assert reset_reset_n=0 mid-run: all outputs are 0 immediately (asynchronously), and no CSR write is issued until enable is resampled after release.
